// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the GPR write-port arbiter: write request, mul/div commit record
// and the arbitration state encoding.
package rf_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 64;
    localparam int WAIT_W     = 3;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] wd;
        logic [DATA_W-1:0]     data;
    } RF_WR_REQ;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] wd;
        logic [DATA_W-1:0]     data;
    } MD_COMMIT;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        STARVE
    } ARB_STATE;

    // x0 is hardwired to zero, so writes to it are architecturally invisible.
    function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] wd);
        return wd != '0;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the writeback, mul/div, stall-vote and register-file signals around the arbiter.
interface rf_write_arbiter_if;

    logic        pipeWe;
    logic [4:0]  pipeWd;
    logic [63:0] pipeData;
    logic        mdValid;
    logic        mdReady;
    logic [4:0]  mdWd;
    logic [63:0] mdData;
    logic        ok_to_proceed_overall;
    logic        ok_to_proceed;
    logic        rfWe;
    logic [4:0]  rfWa;
    logic [63:0] rfWd;
    logic        mdCommitValid;
    logic [4:0]  mdCommitWd;
    logic [63:0] mdCommitData;
    logic        pendingValid;
    logic [4:0]  pendingWd;

    modport master (
        output pipeWe, pipeWd, pipeData, mdValid, mdWd, mdData, ok_to_proceed_overall,
        input  mdReady, ok_to_proceed, rfWe, rfWa, rfWd,
        input  mdCommitValid, mdCommitWd, mdCommitData, pendingValid, pendingWd
    );

    modport slave (
        input  pipeWe, pipeWd, pipeData, mdValid, mdWd, mdData, ok_to_proceed_overall,
        output mdReady, ok_to_proceed, rfWe, rfWa, rfWd,
        output mdCommitValid, mdCommitWd, mdCommitData, pendingValid, pendingWd
    );

endinterface

// File: rtl/rf_write_arbiter_hold_buffer.sv
// One-entry parking slot for a mul/div result that lost the write port, plus a
// counter of how many cycles it has been waiting.
module hold_buffer
    import rf_write_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [REG_ADDR_W-1:0] load_wd,
    input  logic [DATA_W-1:0]     load_data,
    input  logic                  release_buf,
    output logic                  buf_valid,
    output logic [REG_ADDR_W-1:0] buf_wd,
    output logic [DATA_W-1:0]     buf_data,
    output logic [WAIT_W-1:0]     wait_cnt
);

    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [WAIT_W-1:0]     cnt_q, cnt_d;

    // Release (granted or WAW-killed) wins; the counter saturates rather than wrapping.
    always_comb begin
        valid_d = valid_q;
        wd_d    = wd_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (release_buf) begin
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (load) begin
            valid_d = 1'b1;
            wd_d    = load_wd;
            data_d  = load_data;
            cnt_d   = '0;
        end else if (valid_q && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            wd_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wd_q    <= wd_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign buf_valid = valid_q;
    assign buf_wd    = wd_q;
    assign buf_data  = data_q;
    assign wait_cnt  = cnt_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single GPR write port between pipeline writeback (priority) and the
// mul/div unit, parking losing results and forcing a stall if they starve.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT - 1);

    logic                  buf_valid;
    logic [REG_ADDR_W-1:0] buf_wd;
    logic [DATA_W-1:0]     buf_data;
    logic [WAIT_W-1:0]     wait_cnt;

    logic handshake, pipe_grant, buf_grant, bypass_grant, buf_load, waw_inval;

    ARB_STATE state_q, state_d;
    RF_WR_REQ wr_q, wr_d;
    MD_COMMIT commit_q, commit_d;

    // A stalled pipeline will re-present its write, so it only beats an occupied buffer
    // when the pipeline is actually advancing.
    always_comb begin
        handshake    = bus.mdValid && !buf_valid;
        pipe_grant   = bus.pipeWe && (bus.ok_to_proceed_overall || !buf_valid);
        buf_grant    = buf_valid && !pipe_grant;
        bypass_grant = handshake && !pipe_grant;
        buf_load     = handshake && pipe_grant && writes_reg(bus.mdWd);
        waw_inval    = pipe_grant && buf_valid && (bus.pipeWd == buf_wd);
    end

    hold_buffer u_hold_buffer (
        .clk         (clk),
        .rst         (rst),
        .load        (buf_load),
        .load_wd     (bus.mdWd),
        .load_data   (bus.mdData),
        .release_buf (buf_grant || waw_inval),
        .buf_valid   (buf_valid),
        .buf_wd      (buf_wd),
        .buf_data    (buf_data),
        .wait_cnt    (wait_cnt)
    );

    always_comb begin
        wr_d           = wr_q;
        wr_d.we        = 1'b0;
        commit_d       = commit_q;
        commit_d.valid = 1'b0;
        if (pipe_grant) begin
            wr_d.we   = writes_reg(bus.pipeWd);
            wr_d.wd   = bus.pipeWd;
            wr_d.data = bus.pipeData;
        end else if (buf_grant) begin
            wr_d.we        = writes_reg(buf_wd);
            wr_d.wd        = buf_wd;
            wr_d.data      = buf_data;
            commit_d.valid = writes_reg(buf_wd);
            commit_d.wd    = buf_wd;
            commit_d.data  = buf_data;
        end else if (bypass_grant) begin
            wr_d.we        = writes_reg(bus.mdWd);
            wr_d.wd        = bus.mdWd;
            wr_d.data      = bus.mdData;
            commit_d.valid = writes_reg(bus.mdWd);
            commit_d.wd    = bus.mdWd;
            commit_d.data  = bus.mdData;
        end
        // The overwritten result never reaches the file but must still retire in order.
        if (waw_inval) begin
            commit_d.valid = writes_reg(buf_wd);
            commit_d.wd    = buf_wd;
            commit_d.data  = buf_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (buf_load) state_d = HELD;
            HELD: begin
                if (buf_grant || waw_inval)    state_d = IDLE;
                else if (wait_cnt == WAIT_LIMIT) state_d = STARVE;
            end
            STARVE: if (buf_grant || waw_inval) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_q     <= '0;
            commit_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            commit_q <= commit_d;
        end
    end

    assign bus.mdReady       = !buf_valid;
    assign bus.ok_to_proceed = (state_q != STARVE);
    assign bus.rfWe          = wr_q.we;
    assign bus.rfWa          = wr_q.wd;
    assign bus.rfWd          = wr_q.data;
    assign bus.mdCommitValid = commit_q.valid;
    assign bus.mdCommitWd    = commit_q.wd;
    assign bus.mdCommitData  = commit_q.data;
    assign bus.pendingValid  = buf_valid;
    assign bus.pendingWd     = buf_wd;

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single GPR write port between the in-order pipeline writeback and the long-latency mul/div unit. It sits between the writeback stage and the register file. The pipeline write always has priority. A mul/div result that loses arbitration is parked in a one-entry holding buffer. If the result waits too long, the arbiter withholds `ok_to_proceed` to force a pipeline stall so the buffer can drain. It also emits a commit record for every mul/div write so the commit/difftest path sees it.

## Interface
Parameters:
- `MAX_WAIT`, default 4: cycles a buffered result may lose arbitration before the arbiter forces a stall; legal range 1..7.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `pipeWe`  in  1  pipeline writeback request this cycle
- `pipeWd`  in  5  pipeline destination register
- `pipeData`  in  64  pipeline write data
- `mdValid`  in  1  mul/div result valid
- `mdReady`  out  1  arbiter can take a mul/div result
- `mdWd`  in  5  mul/div destination register
- `mdData`  in  64  mul/div result
- `ok_to_proceed_overall`  in  1  global pipeline advance, the AND of all stage `ok_to_proceed` signals
- `ok_to_proceed`  out  1  this block's vote toward `ok_to_proceed_overall`
- `rfWe`  out  1  register-file write enable, registered
- `rfWa`  out  5  register-file write address, registered
- `rfWd`  out  64  register-file write data, registered
- `mdCommitValid`  out  1  one-cycle pulse: a mul/div result was written this cycle
- `mdCommitWd`  out  5  register of that write
- `mdCommitData`  out  64  data of that write
- `pendingValid`  out  1  the holding buffer is occupied
- `pendingWd`  out  5  destination of the buffered result; hazard logic uses it to stall readers

## Operation
- The holding buffer is one entry: `bufValid`, `bufWd`, `bufData`.
- `mdReady` is combinational and equals `!bufValid`.
- A mul/div handshake occurs when `mdValid && mdReady`.
- States:
  - IDLE: buffer empty.
  - HELD: buffer full, waiting for the port.
  - STARVE: buffer full, arbiter is forcing a stall.
- Grant rules, evaluated each cycle:
  - `pipeWe && ok_to_proceed_overall`: the pipeline is granted unconditionally.
  - `pipeWe && !ok_to_proceed_overall`: this is a repeatable write, because the stalled pipeline re-presents it. The pipeline is granted only if the buffer is empty.
  - Otherwise, if the buffer is full, the buffer is granted.
  - Otherwise, if a mul/div handshake occurs, the incoming result is granted directly (bypass) and is not buffered.
  - A handshake that is not granted loads the buffer.
- Writes with destination x0 are suppressed: `rfWe` stays 0 and there is no commit pulse. A handshake targeting x0 is still accepted and dropped.
- WAW rule: if the pipeline is granted with `pipeWd == bufWd` and `bufValid`, the buffer is invalidated without being written. The pipeline write is younger by construction. The commit pulse for the dropped result is still emitted that cycle, carrying the buffered data, so commit ordering stays complete.
- `waitCnt` (3 bits) is cleared on buffer load and increments each cycle the buffer is full and not granted.
- State transitions:
  - IDLE→HELD on a buffer load.
  - HELD→STARVE when `waitCnt == MAX_WAIT-1` and the buffer is not granted this cycle.
  - HELD or STARVE→IDLE when the buffer is granted or invalidated.
- `ok_to_proceed` is 1 in IDLE and HELD, and 0 in STARVE. The resulting `!ok_to_proceed_overall` therefore lets the buffer win the next cycle.
- `pendingValid = bufValid`; `pendingWd = bufWd`.

## Timing
- Reset values:
  - `rfWe`=0, `rfWa`=0, `rfWd`=0
  - `mdCommitValid`=0, `mdCommitWd`=0, `mdCommitData`=0
  - `bufValid`=0, state IDLE, `waitCnt`=0
  - so `mdReady`=1, `ok_to_proceed`=1, `pendingValid`=0
- A grant in cycle N drives `rfWe/rfWa/rfWd` (and the commit outputs for mul/div grants) from edge N+1 for exactly one cycle.
- Maximum extra latency for a mul/div result is `MAX_WAIT+1` cycles from buffer load to port write.
- A buffer grant and a new handshake cannot coincide, because `mdReady` is 0 while the buffer is full. The new result is accepted the cycle after the buffer drains.
- Reset asserted mid-operation discards the buffer and any in-flight grant. No write is issued after reset deasserts until a new request arrives.

## Structure
- The shared package gets:
  - `RF_WR_REQ` struct: `we`, `wd`, `data`.
  - `MD_COMMIT` struct: `valid`, `wd`, `data`.
  - `ARB_STATE` enum: IDLE, HELD, STARVE.
- One sub-module is natural: `hold_buffer`. It is the one-entry register with load, invalidate and the `waitCnt` counter. The arbitration FSM stays in the top module.

## Test plan
- Mul/div only: `mdValid`, `mdWd`=5, `mdData`=0x11 with `pipeWe`=0 → `rfWe`=1, `rfWa`=5, `rfWd`=0x11 and `mdCommitValid` the next cycle; `pendingValid` stays 0.
- Collision: `pipeWe` (rd 3, 0xAA) and `mdValid` (rd 7, 0xBB) in the same cycle → write x3=0xAA, then x7=0xBB one cycle later; `mdReady` is 0 for exactly one cycle.
- Starvation with `MAX_WAIT`=4: buffer holds rd 9 while `pipeWe`=1 every cycle → `ok_to_proceed`=0 in the cycle after the 4th loss, x9 is written the following cycle, and `ok_to_proceed` returns to 1.
- WAW: buffer holds rd 4=0x1 and the pipeline writes rd 4=0x2 → the register file sees only x4=0x2; `mdCommitValid` pulses with 0x1; the buffer empties.
- x0: `mdValid` with `mdWd`=0 → handshake accepted; `rfWe` stays 0; no commit pulse.
- Reset with the buffer full and in STARVE → all outputs at reset values, `mdReady`=1, and no stale write after deassertion.
